// File: rtl/fetch_unit_p_pkg.sv
// Shared definitions for the fetch stage: run-state encoding, opcode map and
// the halt FSM state type.
package fetch_unit_p_pkg;

   localparam logic EXEC = 1'b1;

   typedef enum logic [4:0] {
      OP_NOP  = 5'd0,
      OP_HALT = 5'd1,
      OP_JUMP = 5'd12,
      OP_JMPR = 5'd13,
      OP_BZ   = 5'd14,
      OP_BNZ  = 5'd15,
      OP_BN   = 5'd16,
      OP_BNN  = 5'd17,
      OP_BC   = 5'd18,
      OP_BNC  = 5'd19
   } opcode_e;

   typedef enum logic {
      FSM_RUN    = 1'b0,
      FSM_HALTED = 1'b1
   } fsm_e;

endpackage

// File: rtl/fetch_unit_p_branch_cond.sv
// Combinational redirect decision for the instruction in MEM; kept separate so
// the EX forwarding logic can reuse it.
module fetch_unit_p_branch_cond
   import fetch_unit_p_pkg::*;
#(
   parameter int OP_W = 5
) (
   input  logic [OP_W-1:0] op_i,
   input  logic            zf_i,
   input  logic            nf_i,
   input  logic            cf_i,
   output logic            taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (op_i)
         OP_W'(OP_BZ):   taken_o = zf_i;
         OP_W'(OP_BNZ):  taken_o = ~zf_i;
         OP_W'(OP_BN):   taken_o = nf_i;
         OP_W'(OP_BNN):  taken_o = ~nf_i;
         OP_W'(OP_BC):   taken_o = cf_i;
         OP_W'(OP_BNC):  taken_o = ~cf_i;
         OP_W'(OP_JUMP): taken_o = 1'b1;
         OP_W'(OP_JMPR): taken_o = 1'b1;
         default:        taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_unit_p.sv
// Instruction-fetch stage: PC, IF/ID latch with sideband, redirect/squash
// handling and a halt FSM.
module fetch_unit_p
   import fetch_unit_p_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              IR_W     = 16,
   parameter int              DATA_W   = 16,
   parameter int              OP_HI    = 15,
   parameter int              OP_W     = 5,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [IR_W-1:0] NOP_IR   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              state_i,
   input  logic              stall_i,
   input  logic [DATA_W-1:0] reg_c_i,
   input  logic              zf_i,
   input  logic              nf_i,
   input  logic              cf_i,
   input  logic [IR_W-1:0]   mem_ir_i,
   input  logic [IR_W-1:0]   i_datain_i,
   output logic [PC_W-1:0]   i_addr_o,
   output logic [IR_W-1:0]   id_ir_o,
   output logic [PC_W-1:0]   id_pc_o,
   output logic              id_valid_o,
   output logic              squash_o,
   output logic              halted_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [IR_W-1:0] id_ir_q;
   logic [PC_W-1:0] id_pc_q;
   logic            id_valid_q;
   logic            squash_q;
   fsm_e            fsm_q;

   logic            taken;
   logic            fetch_is_halt;
   logic            unused_bits;

   fetch_unit_p_branch_cond #(
      .OP_W (OP_W)
   ) u_branch_cond (
      .op_i    (mem_ir_i[OP_HI -: OP_W]),
      .zf_i    (zf_i),
      .nf_i    (nf_i),
      .cf_i    (cf_i),
      .taken_o (taken)
   );

   assign fetch_is_halt = (i_datain_i[OP_HI -: OP_W] == OP_W'(OP_HALT));
   assign pc_d          = pc_q + PC_W'(1);
   assign unused_bits   = ^{mem_ir_i, reg_c_i};

   // A taken redirect is an older instruction, so it beats both stall and HALTED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         id_ir_q    <= NOP_IR;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
         squash_q   <= 1'b0;
         fsm_q      <= FSM_RUN;
      end else if (state_i == EXEC) begin
         if (taken) begin
            pc_q       <= reg_c_i[PC_W-1:0];
            id_ir_q    <= NOP_IR;
            id_valid_q <= 1'b0;
            squash_q   <= 1'b1;
            fsm_q      <= FSM_RUN;
         end else if (stall_i) begin
            squash_q <= 1'b0;
         end else if (fsm_q == FSM_HALTED) begin
            id_ir_q    <= NOP_IR;
            id_valid_q <= 1'b0;
            squash_q   <= 1'b0;
         end else begin
            id_ir_q    <= i_datain_i;
            id_pc_q    <= pc_q;
            id_valid_q <= 1'b1;
            squash_q   <= 1'b0;
            if (fetch_is_halt) begin
               fsm_q <= FSM_HALTED;
            end else begin
               pc_q <= pc_d;
            end
         end
      end
   end

   assign i_addr_o   = pc_q;
   assign id_ir_o    = id_ir_q;
   assign id_pc_o    = id_pc_q;
   assign id_valid_o = id_valid_q;
   assign squash_o   = squash_q;
   assign halted_o   = (fsm_q == FSM_HALTED);

endmodule

// File: tb/tb_fetch_unit_p.sv
// Directed bench for fetch_unit_p: sequential fetch, wrap, redirects, stall,
// halt FSM and asynchronous reset, against hand-computed values.
module tb_fetch_unit_p;

   localparam logic [15:0] W_HALT = 16'h0800;
   localparam logic [15:0] W_JUMP = 16'h6000;
   localparam logic [15:0] W_JMPR = 16'h6800;
   localparam logic [15:0] W_BZ   = 16'h7000;
   localparam logic [15:0] W_BN   = 16'h8000;
   localparam logic [15:0] W_BC   = 16'h9000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        state;
   logic        stall;
   logic [15:0] reg_c;
   logic        zf, nf, cf;
   logic [15:0] mem_ir;
   logic [15:0] i_datain;
   logic [7:0]  i_addr;
   logic [15:0] id_ir;
   logic [7:0]  id_pc;
   logic        id_valid;
   logic        squash;
   logic        halted;

   logic [15:0] imem [256];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   assign i_datain = imem[i_addr];

   fetch_unit_p dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .state_i    (state),
      .stall_i    (stall),
      .reg_c_i    (reg_c),
      .zf_i       (zf),
      .nf_i       (nf),
      .cf_i       (cf),
      .mem_ir_i   (mem_ir),
      .i_datain_i (i_datain),
      .i_addr_o   (i_addr),
      .id_ir_o    (id_ir),
      .id_pc_o    (id_pc),
      .id_valid_o (id_valid),
      .squash_o   (squash),
      .halted_o   (halted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " i_addr"},   32'(i_addr),   32'h00);
      chk({tag, " id_ir"},    32'(id_ir),    32'h0000);
      chk({tag, " id_pc"},    32'(id_pc),    32'h00);
      chk({tag, " id_valid"}, 32'(id_valid), 32'h0);
      chk({tag, " squash"},   32'(squash),   32'h0);
      chk({tag, " halted"},   32'(halted),   32'h0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) imem[a] = 16'h1000 | 16'(a);
      imem[7] = W_HALT | 16'h0007;

      rst_n = 1'b0; state = 1'b1; stall = 1'b0; reg_c = '0;
      zf = 1'b0; nf = 1'b0; cf = 1'b0; mem_ir = '0;
      #2;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // sequential fetch
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("seq i_addr", 32'(i_addr), 32'(k));
         chk("seq id_pc", 32'(id_pc), 32'(k - 1));
         chk("seq id_ir", 32'(id_ir), 32'(16'h1000 | 16'(k - 1)));
         chk("seq id_valid", 32'(id_valid), 32'h1);
      end

      // wrap: jump to FF (upper reg_C bits ignored), then fetch FF
      mem_ir = W_JUMP; reg_c = 16'hAAFF;
      tick();
      chk("jmp i_addr", 32'(i_addr), 32'hFF);
      chk("jmp squash", 32'(squash), 32'h1);
      chk("jmp id_valid", 32'(id_valid), 32'h0);
      chk("jmp id_ir", 32'(id_ir), 32'h0);
      mem_ir = '0;
      tick();
      chk("wrap i_addr", 32'(i_addr), 32'h00);
      chk("wrap id_pc", 32'(id_pc), 32'hFF);
      chk("wrap id_ir", 32'(id_ir), 32'h10FF);
      chk("wrap squash", 32'(squash), 32'h0);

      // BC taken, then not taken; BN must ignore cf
      mem_ir = W_BC; cf = 1'b1; reg_c = 16'h1234;
      tick();
      chk("bc i_addr", 32'(i_addr), 32'h34);
      chk("bc id_ir", 32'(id_ir), 32'h0);
      chk("bc id_valid", 32'(id_valid), 32'h0);
      chk("bc squash", 32'(squash), 32'h1);
      mem_ir = '0; cf = 1'b0;
      tick();
      chk("bc pulse end", 32'(squash), 32'h0);
      chk("bc next i_addr", 32'(i_addr), 32'h35);
      chk("bc next id_pc", 32'(id_pc), 32'h34);
      mem_ir = W_BC; cf = 1'b0;
      tick();
      chk("bcnt i_addr", 32'(i_addr), 32'h36);
      chk("bcnt squash", 32'(squash), 32'h0);
      chk("bcnt id_valid", 32'(id_valid), 32'h1);
      mem_ir = W_BN; cf = 1'b1; nf = 1'b0;
      tick();
      chk("bn cf-only i_addr", 32'(i_addr), 32'h37);
      chk("bn cf-only squash", 32'(squash), 32'h0);
      cf = 1'b0;

      // back-to-back taken
      mem_ir = W_BZ; zf = 1'b1; reg_c = 16'h0040;
      tick();
      chk("b2b1 i_addr", 32'(i_addr), 32'h40);
      chk("b2b1 squash", 32'(squash), 32'h1);
      mem_ir = W_JMPR; zf = 1'b0; reg_c = 16'h0050;
      tick();
      chk("b2b2 i_addr", 32'(i_addr), 32'h50);
      chk("b2b2 squash", 32'(squash), 32'h1);
      mem_ir = '0;
      tick();
      chk("b2b end squash", 32'(squash), 32'h0);
      chk("b2b end i_addr", 32'(i_addr), 32'h51);

      // stall holds, taken overrides stall
      mem_ir = W_JUMP; reg_c = 16'h0004;
      tick();
      mem_ir = '0;
      tick();
      chk("pre-stall i_addr", 32'(i_addr), 32'h05);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall i_addr", 32'(i_addr), 32'h05);
         chk("stall id_ir", 32'(id_ir), 32'h1004);
         chk("stall id_pc", 32'(id_pc), 32'h04);
         chk("stall id_valid", 32'(id_valid), 32'h1);
      end
      mem_ir = W_JUMP; reg_c = 16'h0009;
      tick();
      chk("stall+jmp i_addr", 32'(i_addr), 32'h09);
      chk("stall+jmp squash", 32'(squash), 32'h1);
      chk("stall+jmp id_valid", 32'(id_valid), 32'h0);
      mem_ir = '0; stall = 1'b0;

      // HALT at pc 7
      mem_ir = W_JUMP; reg_c = 16'h0006;
      tick();
      mem_ir = '0;
      tick();
      chk("pre-halt i_addr", 32'(i_addr), 32'h07);
      chk("pre-halt halted", 32'(halted), 32'h0);
      tick();
      chk("halt halted", 32'(halted), 32'h1);
      chk("halt i_addr", 32'(i_addr), 32'h07);
      chk("halt id_ir", 32'(id_ir), 32'h0807);
      chk("halt id_valid", 32'(id_valid), 32'h1);
      tick();
      chk("halted id_ir", 32'(id_ir), 32'h0);
      chk("halted id_valid", 32'(id_valid), 32'h0);
      chk("halted i_addr", 32'(i_addr), 32'h07);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      tick();
      chk("halt stall-drop halted", 32'(halted), 32'h1);
      chk("halt stall-drop i_addr", 32'(i_addr), 32'h07);
      mem_ir = W_JMPR; reg_c = 16'h0002;
      tick();
      chk("unhalt halted", 32'(halted), 32'h0);
      chk("unhalt i_addr", 32'(i_addr), 32'h02);
      chk("unhalt squash", 32'(squash), 32'h1);
      mem_ir = '0;
      tick();
      chk("resume i_addr", 32'(i_addr), 32'h03);
      chk("resume id_pc", 32'(id_pc), 32'h02);

      // not exec: everything holds, including squash
      state = 1'b0; mem_ir = W_JUMP; reg_c = 16'h0020;
      tick();
      chk("noexec i_addr", 32'(i_addr), 32'h03);
      chk("noexec squash", 32'(squash), 32'h0);
      state = 1'b1;
      tick();
      chk("exec jmp i_addr", 32'(i_addr), 32'h20);
      state = 1'b0;
      tick();
      chk("noexec squash hold", 32'(squash), 32'h1);
      chk("noexec i_addr hold", 32'(i_addr), 32'h20);
      state = 1'b1; mem_ir = '0;
      tick();
      chk("exec again squash", 32'(squash), 32'h0);
      chk("exec again i_addr", 32'(i_addr), 32'h21);

      // async reset mid-redirect, no clock edge
      mem_ir = W_JUMP; reg_c = 16'h0077;
      rst_n = 1'b0;
      #2;
      chk_reset("async rst");
      mem_ir = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post-rst i_addr", 32'(i_addr), 32'h01);
      chk("post-rst id_ir", 32'(id_ir), 32'h1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
